// File: rtl/mmio_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_ctrl
//
// Memory-mapped I/O controller that sits beside the RAM on the CPU memory bus.
// It decodes the I/O window 0x100-0x1FF and provides:
//   0x100 LED    : read/write 8-bit LED latch (write stores write_data[7:0])
//   0x140 SW     : read-only debounced switches; a read clears the change flag
//   0x141 STATUS : read-only {15'b0, sw_changed}; a read leaves the flag alone
//   0x180 HEX    : read/write 16-bit HEX display register (MMIO_HEX_EN only)
//
// Build option:
//   MMIO_HEX_EN  defined   -> HEX register implemented at 0x180
//                undefined -> hex_value tied to 0, 0x180 unmapped
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive cycles a synchronized switch value must differ
//                     from the stable value before it is accepted (>= 1)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clk        in   single clock, all state on the rising edge
//   reset      in   asynchronous active-low reset
//   mem_cmd    in   bus command: 00 none, 01 read, 10 write, 11 none
//   mem_addr   in   bus address
//   write_data in   CPU store data
//   SW         in   raw board switches (asynchronous to clk), [9:8] unused
//   read_data  out  combinational I/O read data, 0 unless a mapped read
//   io_hit     out  combinational: access is claimed by I/O (gates the RAM)
//   LEDR       out  LED latch
//   hex_value  out  HEX register, nibble n drives HEXn
// -----------------------------------------------------------------------------
module mmio_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  input  logic [9:0]  SW,
  output logic [15:0] read_data,
  output logic        io_hit,
  output logic [7:0]  LEDR,
  output logic [15:0] hex_value
);

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam logic [8:0] ADDR_LED    = 9'h100;
  localparam logic [8:0] ADDR_SW     = 9'h140;
  localparam logic [8:0] ADDR_STATUS = 9'h141;
  localparam logic [8:0] ADDR_HEX    = 9'h180;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // State
  logic [7:0]       led_q,     led_d;
  logic [7:0]       sync1_q,   sync1_d;
  logic [7:0]       sync2_q,   sync2_d;
  logic [7:0]       stable_q,  stable_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             changed_q, changed_d;

  // Decode
  logic is_rd_s;
  logic is_wr_s;
  logic hit_led_s;
  logic hit_sw_s;
  logic hit_status_s;
  logic hit_hex_s;
  logic mapped_s;
  logic accept_s;
  logic [15:0] hex_rd_s;

`ifdef MMIO_HEX_EN
  logic [15:0] hex_q, hex_d;
  logic        unused_s;

  assign unused_s  = ^SW[9:8];
  assign hex_rd_s  = hex_q;
  assign hex_value = hex_q;

  // HEX register next value: full 16-bit store on a write hit
  always_comb begin
    hex_d = hex_q;
    if (is_wr_s && hit_hex_s) begin
      hex_d = write_data;
    end else begin
      hex_d = hex_q;
    end
  end

  // HEX register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_q <= 16'h0000;
    end else begin
      hex_q <= hex_d;
    end
  end
`else
  logic unused_s;

  // Without the HEX register the upper store byte has no destination
  assign unused_s  = ^{SW[9:8], write_data[15:8]};
  assign hex_rd_s  = 16'h0000;
  assign hex_value = 16'h0000;
`endif

  // Address and command decode; 2'b11 falls out as "no access"
  always_comb begin
    is_rd_s      = (mem_cmd == CMD_READ);
    is_wr_s      = (mem_cmd == CMD_WRITE);
    hit_led_s    = (mem_addr == ADDR_LED);
    hit_sw_s     = (mem_addr == ADDR_SW);
    hit_status_s = (mem_addr == ADDR_STATUS);
`ifdef MMIO_HEX_EN
    hit_hex_s    = (mem_addr == ADDR_HEX);
`else
    hit_hex_s    = 1'b0;
`endif
    mapped_s     = hit_led_s | hit_sw_s | hit_status_s | hit_hex_s;
  end

  // Bus response: io_hit for reads and writes, read data only for reads
  always_comb begin
    io_hit    = (is_rd_s | is_wr_s) & mapped_s;
    read_data = 16'h0000;
    if (is_rd_s) begin
      case (1'b1)
        hit_led_s:    read_data = {8'h00, led_q};
        hit_sw_s:     read_data = {8'h00, stable_q};
        hit_status_s: read_data = {15'b0, changed_q};
        hit_hex_s:    read_data = hex_rd_s;
        default:      read_data = 16'h0000;
      endcase
    end else begin
      read_data = 16'h0000;
    end
  end

  // LED latch next value
  always_comb begin
    led_d = led_q;
    if (is_wr_s && hit_led_s) begin
      led_d = write_data[7:0];
    end else begin
      led_d = led_q;
    end
  end

  // Switch synchronizer, debounce counter and change flag
  always_comb begin
    sync1_d   = SW[7:0];
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    accept_s  = 1'b0;
    changed_d = changed_q;

    // The counter measures how long sync2 has disagreed with the stable value;
    // any agreement (including a glitch returning) restarts it.
    if (sync2_q == stable_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = CNT_ZERO;
      accept_s = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // A new accept outranks a clearing read in the same cycle
    if (accept_s) begin
      changed_d = 1'b1;
    end else if (is_rd_s && hit_sw_s) begin
      changed_d = 1'b0;
    end else begin
      changed_d = changed_q;
    end
  end

  // LED and switch-path state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q     <= 8'h00;
      sync1_q   <= 8'h00;
      sync2_q   <= 8'h00;
      stable_q  <= 8'h00;
      cnt_q     <= CNT_ZERO;
      changed_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  assign LEDR = led_q;

endmodule
